pe_array_sched: RTL

Sequencer for the 4-PE systolic alignment array. It accepts one query/reference job through a start handshake, clears the array, and sweeps the diagonal counter `ctr` through 0..2L-1. On each step it drives the per-PE reference and query bases, then streams each step's 12-bit traceback word from the array to a downstream consumer. It sits between the job loader and the PE array top, and it owns the array's clock-enable and clear.

---
 rtl/pe_array_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/pe_array_sched.sv
// Job sequencer for the 4-PE systolic alignment array: latches one query/reference job,
// clears the array, sweeps the diagonal counter and streams the traceback words downstream.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; job latches hold their last contents
// CLEAR   | one-cycle array clear, counter rewound to 0
// RUN     | sweeping ctr 0..2L-1, array advances whenever the stream can take a beat
// DRAIN   | array frozen, waiting for the final beat to be accepted
// DONE    | one-cycle completion pulse

module pe_array_sched #(
   parameter int B  = 4,
   parameter int L  = 8,
   parameter int BW = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              start_ready,
   input  logic [BW*L-1:0]   ref_seq,
   input  logic [BW*B-1:0]   qry_seq,
   input  logic              abort,
   output logic [7:0]        ctr,
   output logic [BW*B-1:0]   R,
   output logic [BW*B-1:0]   Q,
   output logic              pe_en,
   output logic              pe_clr,
   input  logic [BW*B-1:0]   out_pe,
   output logic              tb_valid,
   input  logic              tb_ready,
   output logic [BW*B-1:0]   tb_data,
   output logic [7:0]        tb_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [7:0] CTR_LAST = 8'(2*L-1);

   logic [2:0]      state;
   logic [BW*L-1:0] ref_lat;
   logic [BW*B-1:0] qry_lat;

   assign start_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign pe_clr      = (state == S_CLEAR);
   assign done        = (state == S_DONE);
   // the array only steps when the previous beat has left or is leaving now
   assign pe_en       = (state == S_RUN) && (!tb_valid || tb_ready);
   assign tb_data     = out_pe;
   assign Q           = (state == S_RUN) ? qry_lat : '0;

   always_comb begin
      R = '0;
      if (state == S_RUN) begin
         for (int i = 0; i < B; i++) begin
            if ((int'(ctr) >= i) && (int'(ctr) < i + L))
               R[BW*i +: BW] = ref_lat[BW*(int'(ctr) - i) +: BW];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         ctr      <= '0;
         ref_lat  <= '0;
         qry_lat  <= '0;
         tb_valid <= 1'b0;
         tb_idx   <= '0;
      end else if (abort && (state != S_IDLE)) begin
         state    <= S_IDLE;
         ctr      <= '0;
         tb_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ref_lat <= ref_seq;
                  qry_lat <= qry_seq;
                  state   <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               ctr      <= '0;
               tb_valid <= 1'b0;
               state    <= S_RUN;
            end
            S_RUN: begin
               if (pe_en) begin
                  tb_valid <= 1'b1;
                  tb_idx   <= ctr;
                  if (ctr == CTR_LAST)
                     state <= S_DRAIN;
                  else
                     ctr <= ctr + 8'd1;
               end
            end
            S_DRAIN: begin
               if (tb_valid && tb_ready && (tb_idx == CTR_LAST)) begin
                  tb_valid <= 1'b0;
                  state    <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
